// File: rtl/rv32_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and stream length width.
package rv32_pkg;

  localparam int LOADER_LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  typedef logic [LOADER_LEN_W:0] len_ext_t;

  function automatic logic loader_busy(input loader_state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_pack.sv
// Byte-to-word assembler: collects four little-endian bytes and emits a one-cycle word_valid
// with the completed word held stable in word_data until the next word completes.
module imem_loader_pack
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_cnt,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shreg;

  // word_data is a separate register so the next word can start shifting in
  // during the cycle the previous word is being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= 2'd0;
      shreg      <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= 2'd0;
        shreg    <= 24'd0;
      end else if (byte_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          word_data  <= {byte_data, shreg};
          word_valid <= 1'b1;
        end else begin
          shreg <= {byte_data, shreg[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads an instruction image from a byte stream into IMEM, holding the core in reset
// until the image arrives with a good checksum.
//
// state   | meaning
// IDLE    | no session yet; core runs the built-in image
// LEN_LO  | waiting for word-count low byte
// LEN_HI  | waiting for word-count high byte; range check
// DATA    | receiving payload bytes, writing one word per 4 bytes
// CSUM    | waiting for XOR checksum byte
// DONE    | image loaded and verified; core released
// ERR     | length or checksum failure; core held in reset
module imem_loader
  import rv32_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  localparam len_ext_t DEPTH_L = len_ext_t'(DEPTH_WORDS);

  loader_state_e           state;
  loader_state_e           nxt;
  logic [7:0]              len_lo;
  logic [LOADER_LEN_W-1:0] len;
  logic [LOADER_LEN_W-1:0] words_done;
  logic [7:0]              csum;
  logic [1:0]              byte_cnt;
  logic                    accept;
  logic                    start;
  logic                    data_byte;
  logic [LOADER_LEN_W-1:0] len_full;

  assign accept    = in_valid && in_ready;
  assign start     = load_req && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign data_byte = accept && (state == ST_DATA);
  assign len_full  = {in_data, len_lo};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (load_req) nxt = ST_LEN_LO;
      ST_LEN_LO: if (accept) nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH_L)  nxt = ST_ERR;
          else if (len_full == '0)         nxt = ST_CSUM;
          else                             nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && (byte_cnt == 2'd3) && (words_done == len - 1'b1)) nxt = ST_CSUM;
      end
      ST_CSUM: if (accept) nxt = (in_data == csum) ? ST_DONE : ST_ERR;
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they always agree with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= 8'd0;
      len        <= '0;
      words_done <= '0;
      csum       <= 8'd0;
      imem_addr  <= '0;
    end else begin
      state      <= nxt;
      in_ready   <= loader_busy(nxt);
      core_rst_n <= (nxt == ST_IDLE) || (nxt == ST_DONE);
      done       <= (nxt == ST_DONE);
      err        <= (nxt == ST_ERR);
      if (start) begin
        len_lo     <= 8'd0;
        len        <= '0;
        words_done <= '0;
        csum       <= 8'd0;
      end
      if (accept && (state == ST_LEN_LO)) len_lo <= in_data;
      if (accept && (state == ST_LEN_HI)) len <= len_full;
      if (data_byte) begin
        csum <= csum ^ in_data;
        if (byte_cnt == 2'd3) begin
          imem_addr  <= words_done[ADDR_W-1:0];
          words_done <= words_done + 1'b1;
        end
      end
    end
  end

  imem_loader_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start),
    .byte_valid (data_byte),
    .byte_data  (in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (imem_we),
    .word_data  (imem_wdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stream table plus hand sequences for reset, stalls and boundaries.
module tb_imem_loader;

  localparam int DEPTH_WORDS = 2048;
  localparam int ADDR_W      = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_req = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic              err;

  imem_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(32'(imem_addr));
      wr_data_q.push_back(imem_wdata);
    end
  end

  typedef struct {
    string       name;
    logic [87:0] bytes;
    int          nbytes;
    bit          stall;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) chk("ready_timeout", 32'(tries), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_result(input vec_t v);
    logic [31:0] exp_w[2];
    exp_w[0] = v.w0;
    exp_w[1] = v.w1;
    chk({v.name, "_done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "_core_rst_n"}, 32'(core_rst_n), 32'(v.exp_done));
    chk({v.name, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({v.name, "_nwrites"}, 32'(wr_addr_q.size()), 32'(v.nwr));
    for (int i = 0; i < v.nwr && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", v.name, i), wr_addr_q[i], 32'(i));
      chk($sformatf("%s_data%0d", v.name, i), wr_data_q[i], exp_w[i]);
    end
  endtask

  task automatic run_vec(input vec_t v);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    chk({v.name, "_start_done_clr"}, 32'(done), 32'd0);
    chk({v.name, "_start_err_clr"}, 32'(err), 32'd0);
    chk({v.name, "_start_core_rst"}, 32'(core_rst_n), 32'd0);
    for (int i = 0; i < v.nbytes; i++)
      send_byte(v.bytes[87-8*i -: 8], v.stall ? int'($urandom_range(0, 5)) : 0);
    repeat (3) @(negedge clk);
    check_result(v);
  endtask

  localparam logic [87:0] GOOD = 88'h02_00_93_00_50_00_13_01_A0_00_71;
  localparam logic [87:0] BADC = 88'h02_00_93_00_50_00_13_01_A0_00_70;

  initial begin
    vec_t v;
    vecs[0] = '{"good",     GOOD, 11, 1'b0, 2, 32'h00500093, 32'h00A00113, 1'b1, 1'b0};
    vecs[1] = '{"bad_csum", BADC, 11, 1'b0, 2, 32'h00500093, 32'h00A00113, 1'b0, 1'b1};
    vecs[2] = '{"oversize", {8'h01, 8'h08, 72'h0}, 2, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{"zero_ok",  {8'h00, 8'h00, 8'h00, 64'h0}, 3, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{"zero_bad", {8'h00, 8'h00, 8'hFF, 64'h0}, 3, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[5] = '{"stall",    GOOD, 11, 1'b1, 2, 32'h00500093, 32'h00A00113, 1'b1, 1'b0};
    vecs[6] = '{"stall_bad", BADC, 11, 1'b1, 2, 32'h00500093, 32'h00A00113, 1'b0, 1'b1};

    // Reset values while asserted, then release.
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // load_req in the middle of DATA must not restart the session.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    for (int i = 0; i < 5; i++) send_byte(GOOD[87-8*i -: 8], 0);
    pulse_load();
    chk("midload_in_ready", 32'(in_ready), 32'd1);
    for (int i = 5; i < 11; i++) send_byte(GOOD[87-8*i -: 8], 0);
    repeat (3) @(negedge clk);
    v = vecs[0];
    v.name = "midload";
    check_result(v);

    // Async reset after 6 payload bytes: only word 0 lands, partial word dropped.
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    for (int i = 0; i < 8; i++) send_byte(GOOD[87-8*i -: 8], 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("midrst_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      chk("midrst_addr0", wr_addr_q[0], 32'd0);
      chk("midrst_data0", wr_data_q[0], 32'h00500093);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("midrst_idle_done", 32'(done), 32'd0);
    chk("midrst_nwrites_after", 32'(wr_addr_q.size()), 32'd1);
    v = vecs[0];
    v.name = "after_rst";
    run_vec(v);

    // N == DEPTH_WORDS is legal and enters DATA.
    pulse_load();
    send_byte(8'h00, 0);
    send_byte(8'h08, 0);
    repeat (2) @(negedge clk);
    chk("n2048_err", 32'(err), 32'd0);
    chk("n2048_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach end, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, 2048, instruction-memory depth in 32-bit words.
REQ-002 Parameter: ADDR_W, $clog2(DEPTH_WORDS), word-address width.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load_req  input  1  one-cycle pulse that starts a load session.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte-stream ready; a byte transfers when in_valid && in_ready.
REQ-009 imem_we  output  1  IMEM write strobe, one cycle per word.
REQ-010 imem_addr  output  ADDR_W  IMEM word address.
REQ-011 imem_wdata  output  32  IMEM write data.
REQ-012 core_rst_n  output  1  active-low reset to RV32I_Pipline; low while loading or after an error.
REQ-013 done  output  1  level; last session completed with a good checksum.
REQ-014 err  output  1  level; last session failed (length or checksum).

Function
REQ-015 Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes (each word little-endian, byte 0 = bits 7:0), then 1 checksum byte.
REQ-016 Checksum: XOR of all 4*N payload bytes; the length bytes are excluded.
REQ-017 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-018 IDLE/DONE/ERR + load_req -> LEN_LO; clear done, err, checksum accumulator, word index, byte counter.
REQ-019 load_req seen in LEN_LO..CSUM: ignored.
REQ-020 in_ready = 1 only in LEN_LO, LEN_HI, DATA, CSUM; 0 otherwise.
REQ-021 LEN_HI accepted: N > DEPTH_WORDS -> ERR; N == 0 -> CSUM; else -> DATA.
REQ-022 DATA: 2-bit byte counter; on the 4th byte, the assembled word is written; imem_we is high exactly the cycle after that byte is accepted, with imem_addr = word index (starting at 0); word index then increments.
REQ-023 After word N-1 is accepted -> CSUM; byte counter wraps 3->0 between words.
REQ-024 CSUM accepted: byte == accumulator -> DONE; else -> ERR.
REQ-025 core_rst_n = 1 in IDLE and DONE; 0 in LEN_LO..CSUM and ERR.
REQ-026 done = 1 only in DONE; err = 1 only in ERR.
REQ-027 Stalls: in_valid low for any number of cycles holds all state; no byte is lost or duplicated.
REQ-028 imem_we is never asserted outside DATA-word completion; imem_addr/imem_wdata are don't-care when imem_we = 0 but held stable.
REQ-029 Words already written before an ERR remain in IMEM; no rollback.

Reset
REQ-030 rst_n low (async): state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, err 0, core_rst_n 0 while asserted, then 1 from IDLE (the core runs the IMEM_INIT image).
REQ-031 Reset mid-session aborts the session; the partial word is discarded and no write is issued.

Structure
REQ-032 rv32_pkg holds the loader state enum (loader_state_e) and the constant LOADER_LEN_W = 16.
REQ-033 One sub-module: imem_loader_pack (byte-to-word shift assembler with the 2-bit byte counter and a word_valid pulse); the FSM, checksum and address counter live in imem_loader.

Verification
REQ-034 Good load: load_req; bytes 02 00 93 00 50 00 13 01 A0 00 71 -> writes addr0=00500093, addr1=00A00113; then done = 1, core_rst_n = 1.
REQ-035 Bad checksum: same stream with last byte 70 -> both words written; err = 1, core_rst_n stays 0.
REQ-036 Oversize: bytes 01 08 (N = 2049) -> ERR after the second byte; no imem_we ever asserted.
REQ-037 Zero length: bytes 00 00 00 -> DONE with no writes; bytes 00 00 FF -> ERR.
REQ-038 Stalls: the REQ-034 stream with random in_valid gaps of 0-5 cycles -> identical writes and result; also load_req mid-DATA is ignored.
REQ-039 Reset mid-DATA: rst_n low after 6 payload bytes -> only addr0 written; state IDLE, core_rst_n = 1 after release, and a new load succeeds.
